// File: rtl/ub_delay_pkg.sv
// Shared helpers for the unified-buffer multi-tap delay line: pointer sizing
// and extraction of per-tap delays from the packed delay parameter.
package ub_delay_pkg;

  localparam int DELAY_FIELD_W = 32;
  localparam int MAX_TAPS      = 32;
  localparam int TAP_BITS      = MAX_TAPS * DELAY_FIELD_W;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Callers widen their packed delay vector to TAP_BITS before calling.
  function automatic int tap_delay(input logic [TAP_BITS-1:0] delays, input int idx);
    return int'(delays[idx*DELAY_FIELD_W +: DELAY_FIELD_W]);
  endfunction

endpackage

// File: rtl/ub_delay_storage.sv
// Circular sample store: one synchronous write port and NUM_RD combinational
// read ports. Contents are deliberately not reset.
module ub_delay_storage
  import ub_delay_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 68,
  parameter int NUM_RD = 4,
  parameter int AW     = ptr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    assign rdata[r*WIDTH +: WIDTH] = mem[raddr[r*AW +: AW]];
  end

endmodule

// File: rtl/ub_multitap_delay_line.sv
// Multi-tap delay line: one circular store read at NUM_TAPS fixed delays,
// with stall enable, synchronous flush and per-tap valid masking.
module ub_multitap_delay_line
  import ub_delay_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_TAPS  = 4,
  parameter int MAX_DELAY = 68,
  parameter logic [NUM_TAPS*32-1:0] TAP_DELAYS = {32'd4, 32'd3, 32'd67, 32'd68}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           en,
  input  logic [WIDTH-1:0]               in,
  output logic [NUM_TAPS*WIDTH-1:0]      out,
  output logic [NUM_TAPS-1:0]            out_valid,
  output logic [$clog2(MAX_DELAY+1)-1:0] fill_count
);

  localparam int PW = ptr_w(MAX_DELAY);
  localparam int CW = $clog2(MAX_DELAY + 1);

  localparam logic [PW-1:0]       PTR_LAST  = PW'(MAX_DELAY - 1);
  localparam logic [CW-1:0]       FILL_MAX  = CW'(MAX_DELAY);
  localparam logic [PW:0]         DEPTH_X   = (PW+1)'(MAX_DELAY);
  localparam logic [TAP_BITS-1:0] TAPS_EXT  = TAP_BITS'(TAP_DELAYS);

  logic [PW-1:0]             wr_ptr;
  logic [PW:0]               wr_ext;
  logic                      wr_en;
  logic [NUM_TAPS*PW-1:0]    rd_addr;
  logic [NUM_TAPS*WIDTH-1:0] rd_data;

  if (NUM_TAPS < 1 || NUM_TAPS > MAX_TAPS) begin : g_bad_taps
    $error("ub_multitap_delay_line: NUM_TAPS=%0d out of range", NUM_TAPS);
  end

  // Flush wins over enable, so a flushing edge never writes the store.
  assign wr_en  = en && !flush;
  assign wr_ext = {1'b0, wr_ptr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (en) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (fill_count != FILL_MAX) begin
        fill_count <= fill_count + 1'b1;
      end
    end
  end

  ub_delay_storage #(
    .WIDTH  (WIDTH),
    .DEPTH  (MAX_DELAY),
    .NUM_RD (NUM_TAPS),
    .AW     (PW)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
    localparam int            D   = tap_delay(TAPS_EXT, g);
    localparam logic [PW:0]   D_X = (PW+1)'(D);
    localparam logic [CW-1:0] D_C = CW'(D);

    if (D < 1 || D > MAX_DELAY) begin : g_bad_delay
      $error("ub_multitap_delay_line: tap %0d delay %0d outside 1..%0d", g, D, MAX_DELAY);
    end

    // Modular subtraction kept non-negative; a full-depth delay lands on wr_ptr.
    assign rd_addr[g*PW +: PW] = (wr_ext >= D_X) ? PW'(wr_ext - D_X)
                                                 : PW'(wr_ext + DEPTH_X - D_X);
    assign out_valid[g]            = (fill_count >= D_C);
    assign out[g*WIDTH +: WIDTH]   = out_valid[g] ? rd_data[g*WIDTH +: WIDTH] : '0;
  end

endmodule

// File: tb/tb_ub_multitap_delay_line.sv
// Self-checking bench for ub_multitap_delay_line: a history-queue reference
// model feeding a scoreboard, vector tables, and small-parameter instances.
module tb_ub_multitap_delay_line;

  localparam int WA = 16;
  localparam int NA = 4;
  localparam int MA = 68;
  // Packed so tap0..tap3 carry delays 4, 3, 67, 68.
  localparam logic [NA*32-1:0] TAPS_A = {32'd68, 32'd67, 32'd3, 32'd4};

  localparam int WB = 16;
  localparam int NB = 2;
  localparam int MB = 5;
  // tap0 delay 1, tap1 delay 5.
  localparam logic [NB*32-1:0] TAPS_B = {32'd5, 32'd1};

  typedef struct {
    logic [63:0] out;
    logic [63:0] valid;
    logic [63:0] fill;
  } exp_t;

  typedef struct {
    logic        flush;
    logic        en;
    logic [15:0] din;
    logic        exp_v1;
    logic [15:0] exp_o1;
    int          exp_fill;
  } vec_t;

  typedef struct {
    logic       flush;
    logic       en;
    logic [7:0] din;
    logic       exp_v;
    logic [7:0] exp_o;
    int         exp_fill;
  } vec_c_t;

  logic clk = 1'b0;
  logic rst_n;

  logic             flush_a, en_a;
  logic [WA-1:0]    in_a;
  logic [NA*WA-1:0] out_a;
  logic [NA-1:0]    valid_a;
  logic [6:0]       fill_a;

  logic             flush_b, en_b;
  logic [WB-1:0]    in_b;
  logic [NB*WB-1:0] out_b;
  logic [NB-1:0]    valid_b;
  logic [2:0]       fill_b;

  logic       flush_c, en_c;
  logic [7:0] in_c;
  logic [7:0] out_c;
  logic [0:0] valid_c;
  logic [0:0] fill_c;

  exp_t          exp_q[$];
  logic [WA-1:0] hist_a[$];
  vec_t          vecs[14];
  vec_c_t        vecs_c[6];
  int            checks = 0;
  int            fails  = 0;

  always #5 clk = ~clk;

  ub_multitap_delay_line #(
    .WIDTH(WA), .NUM_TAPS(NA), .MAX_DELAY(MA), .TAP_DELAYS(TAPS_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .en(en_a), .in(in_a),
    .out(out_a), .out_valid(valid_a), .fill_count(fill_a)
  );

  ub_multitap_delay_line #(
    .WIDTH(WB), .NUM_TAPS(NB), .MAX_DELAY(MB), .TAP_DELAYS(TAPS_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .en(en_b), .in(in_b),
    .out(out_b), .out_valid(valid_b), .fill_count(fill_b)
  );

  ub_multitap_delay_line #(
    .WIDTH(8), .NUM_TAPS(1), .MAX_DELAY(1), .TAP_DELAYS(32'd1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .en(en_c), .in(in_c),
    .out(out_c), .out_valid(valid_c), .fill_count(fill_c)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference for instance A: newest accepted sample at index 0.
  function automatic exp_t model_a();
    exp_t x;
    int   d;
    x.out   = '0;
    x.valid = '0;
    x.fill  = 64'(hist_a.size());
    for (int i = 0; i < NA; i++) begin
      d = int'(TAPS_A[32*i +: 32]);
      if (hist_a.size() >= d) begin
        x.valid[i]         = 1'b1;
        x.out[WA*i +: WA]  = hist_a[d-1];
      end
    end
    return x;
  endfunction

  task automatic applyStimulus(input logic f, input logic e, input logic [WA-1:0] d);
    exp_t x;
    flush_a = f;
    en_a    = e;
    in_a    = d;
    if (f) begin
      hist_a.delete();
    end else if (e) begin
      hist_a.push_front(d);
      if (hist_a.size() > MA) void'(hist_a.pop_back());
    end
    exp_q.push_back(model_a());
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    checkOutput("a_out",   64'(out_a),   x.out);
    checkOutput("a_valid", 64'(valid_a), x.valid);
    checkOutput("a_fill",  64'(fill_a),  x.fill);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    flush_a = 1'b0;
    en_a    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist_a.delete();
  endtask

  task automatic runRamp(input int n, input int base, input bit spot);
    for (int t = 0; t < n; t++) begin
      applyStimulus(1'b0, 1'b1, 16'(base + t));
      if (spot) begin
        if (t == 2)  checkOutput("d4_not_yet",  64'(valid_a[0]), 64'(0));
        if (t == 3) begin
          checkOutput("d4_first_valid", 64'(valid_a[0]), 64'(1));
          checkOutput("d4_first_data",  64'(out_a[15:0]), 64'(0));
        end
        if (t == 66) checkOutput("d68_not_yet", 64'(valid_a[3]), 64'(0));
        if (t == 67) begin
          checkOutput("d68_first_valid", 64'(valid_a[3]), 64'(1));
          checkOutput("d68_first_data",  64'(out_a[63:48]), 64'(0));
          checkOutput("fill_saturated",  64'(fill_a), 64'(68));
        end
        if (t == 79) begin
          checkOutput("d68_wrapped_data", 64'(out_a[63:48]), 64'(12));
          checkOutput("d4_late_data",     64'(out_a[15:0]),  64'(76));
          checkOutput("fill_held",        64'(fill_a), 64'(68));
        end
      end
    end
  endtask

  initial begin
    exp_t x;

    vecs[0]  = '{1'b0, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 1};
    vecs[1]  = '{1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1};
    vecs[2]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 2};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2};
    vecs[4]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 16'hA5A5, 3};
    vecs[5]  = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'hA5A5, 3};
    vecs[6]  = '{1'b0, 1'b0, 16'h0003, 1'b1, 16'hA5A5, 3};
    vecs[7]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h1234, 4};
    vecs[8]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0001, 5};
    vecs[9]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 0};
    vecs[10] = '{1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000, 1};
    vecs[11] = '{1'b0, 1'b1, 16'h0022, 1'b0, 16'h0000, 2};
    vecs[12] = '{1'b0, 1'b1, 16'h0033, 1'b1, 16'h0011, 3};
    vecs[13] = '{1'b0, 1'b1, 16'h0044, 1'b1, 16'h0022, 4};

    vecs_c[0] = '{1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 0};
    vecs_c[1] = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h22, 1};
    vecs_c[2] = '{1'b0, 1'b0, 8'h33, 1'b1, 8'h22, 1};
    vecs_c[3] = '{1'b0, 1'b1, 8'h44, 1'b1, 8'h44, 1};
    vecs_c[4] = '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 0};
    vecs_c[5] = '{1'b0, 1'b1, 8'h66, 1'b1, 8'h66, 1};

    rst_n = 1'b0;
    flush_a = 1'b0; en_a = 1'b0; in_a = '0;
    flush_b = 1'b0; en_b = 1'b0; in_b = '0;
    flush_c = 1'b0; en_c = 1'b0; in_c = '0;
    @(negedge clk);
    checkOutput("reset_out",   64'(out_a),   64'(0));
    checkOutput("reset_valid", 64'(valid_a), 64'(0));
    checkOutput("reset_fill",  64'(fill_a),  64'(0));
    checkOutput("reset_c_valid", 64'(valid_c), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] continuous stream with ramp data");
    runRamp(80, 0, 1'b1);

    $display("[TB] enable toggling and flush vectors");
    doReset();
    for (int i = 0; i < 14; i++) begin
      if (i == 9) runRamp(100, 16'h100, 1'b0);
      applyStimulus(vecs[i].flush, vecs[i].en, vecs[i].din);
      checkOutput("vec_v1",   64'(valid_a[1]),    64'(vecs[i].exp_v1));
      checkOutput("vec_o1",   64'(out_a[31:16]),  64'(vecs[i].exp_o1));
      checkOutput("vec_fill", 64'(fill_a),        64'(vecs[i].exp_fill));
      if (i == 9) begin
        checkOutput("flush_all_valid", 64'(valid_a), 64'(0));
        checkOutput("flush_all_out",   64'(out_a),   64'(0));
      end
      if (i == 13) checkOutput("flush_d4_refill", 64'(out_a[15:0]), 64'(16'h0011));
    end

    $display("[TB] asynchronous reset mid-stream");
    doReset();
    runRamp(51, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 64'(valid_a), 64'(0));
    checkOutput("async_out",   64'(out_a),   64'(0));
    checkOutput("async_fill",  64'(fill_a),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    hist_a.delete();
    en_a = 1'b0;
    runRamp(70, 0, 1'b1);
    en_a = 1'b0;

    $display("[TB] small depth with pointer wrap");
    for (int t = 0; t < 20; t++) begin
      flush_b = 1'b0;
      en_b    = 1'b1;
      in_b    = 16'(16'h50 + t);
      x.out   = 64'({(t >= 4) ? 16'(16'h50 + t - 4) : 16'h0000, 16'(16'h50 + t)});
      x.valid = 64'({(t >= 4) ? 1'b1 : 1'b0, 1'b1});
      x.fill  = 64'((t + 1 > MB) ? MB : t + 1);
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checkOutput("b_out",   64'(out_b),   x.out);
      checkOutput("b_valid", 64'(valid_b), x.valid);
      checkOutput("b_fill",  64'(fill_b),  x.fill);
      @(negedge clk);
    end
    en_b = 1'b0;

    $display("[TB] single-entry line");
    for (int i = 0; i < 6; i++) begin
      flush_c = vecs_c[i].flush;
      en_c    = vecs_c[i].en;
      in_c    = vecs_c[i].din;
      x.out   = 64'(vecs_c[i].exp_o);
      x.valid = 64'(vecs_c[i].exp_v);
      x.fill  = 64'(vecs_c[i].exp_fill);
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checkOutput("c_out",   64'(out_c),   x.out);
      checkOutput("c_valid", 64'(valid_c), x.valid);
      checkOutput("c_fill",  64'(fill_c),  x.fill);
      @(negedge clk);
    end
    flush_c = 1'b0;
    en_c    = 1'b0;

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
